// File: rtl/mips_pkg.sv
// Shared MIPS core constants: bubble word, instruction field positions,
// fetch FSM encoding and opcodes the load-use stall unit also decodes.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t HOLD  = 2'd1;
    localparam fetch_state_t DRAIN = 2'd2;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] XORI = 6'b001110;

endpackage

// File: rtl/fetch_ifid_stage_if.sv
// Instruction-memory request/acknowledge bus between fetch (master) and imem (slave).
interface fetch_ifid_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; a bubble takes priority over a load so a flush
// always wins against a concurrent write.
module ifid_reg #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc4,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= d_instr;
            pc4   <= d_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Fetch stage: owns the PC, fetches over the imem handshake, parks one word
// in a skid buffer while stalled, and flushes IF/ID on branch or jump.
//
//  state | meaning
//  FETCH | request outstanding at pc
//  HOLD  | fetched word parked in skid buffer, waiting for the stall to clear
//  DRAIN | redirected while a request was pending; wait for its ack, then jump
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       PC_WriteEn,
    input  logic                       IFID_WriteEn,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    input  logic                       jump,
    input  logic [31:0]                jump_target,
    fetch_ifid_stage_if.master         imem,
    output logic [31:0]                ID_instr,
    output logic [31:0]                ID_pc4,
    output logic                       ID_valid,
    output logic [5:0]                 ID_Op,
    output logic [4:0]                 ID_rs,
    output logic [4:0]                 ID_rt
);
    import mips_pkg::*;

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx, pc4, tgt;
    logic [31:0]  skid_instr, skid_pc4;
    logic [31:0]  saved_tgt, saved_tgt_nx;
    logic [31:0]  d_instr, d_pc4;
    logic         started, advance, redirect, ack;
    logic         load, bubble, skid_load;

    assign advance  = PC_WriteEn & IFID_WriteEn;
    assign redirect = branch_taken | jump;
    assign tgt      = (branch_taken ? branch_target : jump_target) & ~32'h3;
    assign pc4      = pc + 32'd4;

    // started gates the request until the first edge after reset release
    assign imem.imem_req  = started & (state != HOLD);
    assign imem.imem_addr = pc;
    assign ack            = imem.imem_ack & imem.imem_req;

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        saved_tgt_nx = saved_tgt;
        load         = 1'b0;
        bubble       = 1'b0;
        skid_load    = 1'b0;
        case (state)
            FETCH: begin
                if (started) begin
                    if (redirect) begin
                        bubble = 1'b1;
                        if (ack) begin
                            pc_nx = tgt;
                        end else begin
                            saved_tgt_nx = tgt;
                            state_nx     = DRAIN;
                        end
                    end else if (ack) begin
                        if (advance) begin
                            load  = 1'b1;
                            pc_nx = pc4;
                        end else begin
                            skid_load = 1'b1;
                            state_nx  = HOLD;
                        end
                    end else if (IFID_WriteEn) begin
                        bubble = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    bubble   = 1'b1;
                    pc_nx    = tgt;
                    state_nx = FETCH;
                end else if (advance) begin
                    load     = 1'b1;
                    pc_nx    = skid_pc4;
                    state_nx = FETCH;
                end
            end
            DRAIN: begin
                bubble = redirect | IFID_WriteEn;
                if (redirect) saved_tgt_nx = tgt;
                if (ack) begin
                    pc_nx    = redirect ? tgt : saved_tgt;
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    assign d_instr = (state == HOLD) ? skid_instr : imem.imem_rdata;
    assign d_pc4   = (state == HOLD) ? skid_pc4   : pc4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            started    <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc4   <= 32'd0;
            saved_tgt  <= 32'd0;
        end else begin
            started   <= 1'b1;
            state     <= state_nx;
            pc        <= pc_nx;
            saved_tgt <= saved_tgt_nx;
            if (skid_load) begin
                skid_instr <= imem.imem_rdata;
                skid_pc4   <= pc4;
            end
        end
    end

    ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .bubble  (bubble),
        .d_instr (d_instr),
        .d_pc4   (d_pc4),
        .instr   (ID_instr),
        .pc4     (ID_pc4),
        .valid   (ID_valid)
    );

    assign ID_Op = ID_instr[OP_HI:OP_LO];
    assign ID_rs = ID_instr[RS_HI:RS_LO];
    assign ID_rt = ID_instr[RT_HI:RT_LO];

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed cycle-table bench for fetch_ifid_stage with a behavioural imem.
module tb_fetch_ifid_stage;

    logic        clk;
    logic        rst_n;
    logic        PC_WriteEn, IFID_WriteEn;
    logic        branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic        ack_en;
    logic [31:0] ID_instr, ID_pc4;
    logic        ID_valid;
    logic [5:0]  ID_Op;
    logic [4:0]  ID_rs, ID_rt;

    int passed = 0;
    int total  = 0;

    fetch_ifid_stage_if imem ();

    fetch_ifid_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_WriteEn    (PC_WriteEn),
        .IFID_WriteEn  (IFID_WriteEn),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem          (imem.master),
        .ID_instr      (ID_instr),
        .ID_pc4        (ID_pc4),
        .ID_valid      (ID_valid),
        .ID_Op         (ID_Op),
        .ID_rs         (ID_rs),
        .ID_rt         (ID_rt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C3A_0000;
    endfunction

    assign imem.imem_ack   = imem.imem_req & ack_en;
    assign imem.imem_rdata = mem_word(imem.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    typedef struct {
        logic        ack_en, pcw, ifw, br;
        logic [31:0] brt;
        logic        jp;
        logic [31:0] jpt;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pc4;
        logic        pc4_chk, e_valid;
    } vec_t;

    function automatic vec_t mk(input logic a, p, f, b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic rq, input logic [31:0] ad, ins, p4,
                                input logic pc4c, v);
        vec_t r;
        r.ack_en = a; r.pcw = p; r.ifw = f; r.br = b; r.brt = bt; r.jp = j; r.jpt = jt;
        r.e_req = rq; r.e_addr = ad; r.e_instr = ins; r.e_pc4 = p4; r.pc4_chk = pc4c; r.e_valid = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                            input logic pc4c, input logic v);
        check({tag, ".instr"}, ID_instr, ins);
        check({tag, ".valid"}, {31'd0, ID_valid}, {31'd0, v});
        check({tag, ".op"}, {26'd0, ID_Op}, {26'd0, ins[31:26]});
        check({tag, ".rs"}, {27'd0, ID_rs}, {27'd0, ins[25:21]});
        check({tag, ".rt"}, {27'd0, ID_rt}, {27'd0, ins[20:16]});
        if (pc4c) check({tag, ".pc4"}, ID_pc4, p4);
    endtask

    vec_t vec [26];

    initial begin
        rst_n = 1'b0; ack_en = 1'b1; PC_WriteEn = 1'b1; IFID_WriteEn = 1'b1;
        branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_target = 32'd0;

        //          ack pcw ifw br brt       jp jpt          req addr        instr               pc4       chk v
        vec[0]  = mk(1, 1, 1, 0, 0,          0, 0,           0, 32'h0,   32'h0,              32'h0,    1, 0);
        vec[1]  = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h0,   mem_word(32'h0),    32'h4,    1, 1);
        vec[2]  = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h4,   mem_word(32'h4),    32'h8,    1, 1);
        vec[3]  = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h8,   mem_word(32'h8),    32'hC,    1, 1);
        vec[4]  = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'hC,   mem_word(32'hC),    32'h10,   1, 1);
        vec[5]  = mk(1, 0, 0, 0, 0,          0, 0,           1, 32'h10,  mem_word(32'hC),    32'h10,   1, 1);
        vec[6]  = mk(1, 0, 0, 0, 0,          0, 0,           0, 32'h10,  mem_word(32'hC),    32'h10,   1, 1);
        vec[7]  = mk(1, 1, 1, 0, 0,          0, 0,           0, 32'h10,  mem_word(32'h10),   32'h14,   1, 1);
        vec[8]  = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h14,  mem_word(32'h14),   32'h18,   1, 1);
        vec[9]  = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h18,  mem_word(32'h18),   32'h1C,   1, 1);
        vec[10] = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h1C,  mem_word(32'h1C),   32'h20,   1, 1);
        vec[11] = mk(1, 1, 1, 1, 32'h200,    0, 0,           1, 32'h20,  32'h0,              32'h0,    0, 0);
        vec[12] = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h200, mem_word(32'h200),  32'h204,  1, 1);
        vec[13] = mk(0, 1, 1, 0, 0,          1, 32'h400,     1, 32'h204, 32'h0,              32'h0,    0, 0);
        vec[14] = mk(0, 1, 1, 0, 0,          0, 0,           1, 32'h204, 32'h0,              32'h0,    0, 0);
        vec[15] = mk(0, 1, 1, 0, 0,          0, 0,           1, 32'h204, 32'h0,              32'h0,    0, 0);
        vec[16] = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h204, 32'h0,              32'h0,    0, 0);
        vec[17] = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h400, mem_word(32'h400),  32'h404,  1, 1);
        vec[18] = mk(1, 1, 0, 1, 32'h103,    1, 32'h800,     1, 32'h404, 32'h0,              32'h0,    0, 0);
        vec[19] = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h100, mem_word(32'h100),  32'h104,  1, 1);
        vec[20] = mk(1, 1, 0, 0, 0,          0, 0,           1, 32'h104, mem_word(32'h100),  32'h104,  1, 1);
        vec[21] = mk(1, 1, 1, 0, 0,          1, 32'h600,     0, 32'h104, 32'h0,              32'h0,    0, 0);
        vec[22] = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h600, mem_word(32'h600),  32'h604,  1, 1);
        vec[23] = mk(0, 0, 0, 0, 0,          0, 0,           1, 32'h604, mem_word(32'h600),  32'h604,  1, 1);
        vec[24] = mk(0, 1, 1, 0, 0,          0, 0,           1, 32'h604, 32'h0,              32'h0,    0, 0);
        vec[25] = mk(1, 1, 1, 0, 0,          0, 0,           1, 32'h604, mem_word(32'h604),  32'h608,  1, 1);

        tick();
        tick();
        check("rst.req", {31'd0, imem.imem_req}, 32'd0);
        check("rst.addr", imem.imem_addr, 32'h0);
        check_id("rst", 32'h0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            ack_en = vec[i].ack_en; PC_WriteEn = vec[i].pcw; IFID_WriteEn = vec[i].ifw;
            branch_taken = vec[i].br; branch_target = vec[i].brt;
            jump = vec[i].jp; jump_target = vec[i].jpt;
            #1;
            check($sformatf("v%0d.req", i), {31'd0, imem.imem_req}, {31'd0, vec[i].e_req});
            check($sformatf("v%0d.addr", i), imem.imem_addr, vec[i].e_addr);
            tick();
            check_id($sformatf("v%0d", i), vec[i].e_instr, vec[i].e_pc4, vec[i].pc4_chk, vec[i].e_valid);
        end

        // jump to the top of the address space, then fetch across the wrap
        ack_en = 1'b1; PC_WriteEn = 1'b1; IFID_WriteEn = 1'b1;
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'hFFFF_FFFE;
        #1 check("wrap.addr0", imem.imem_addr, 32'h608);
        tick();
        jump = 1'b0;
        #1 check("wrap.addr1", imem.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_id("wrap.id", mem_word(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b1);
        check("wrap.addr2", imem.imem_addr, 32'h0);
        tick();
        check_id("wrap.id2", mem_word(32'h0), 32'h4, 1'b1, 1'b1);

        // enter DRAIN at pc=4 and reset asynchronously in the middle of it
        ack_en = 1'b0; jump = 1'b1; jump_target = 32'h40;
        tick();
        jump = 1'b0;
        #1;
        check("drain.req", {31'd0, imem.imem_req}, 32'd1);
        check("drain.addr", imem.imem_addr, 32'h4);
        rst_n = 1'b0;
        #1;
        check("mrst.req", {31'd0, imem.imem_req}, 32'd0);
        check("mrst.addr", imem.imem_addr, 32'h0);
        check_id("mrst", 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1; ack_en = 1'b1;
        tick();
        check("post.req", {31'd0, imem.imem_req}, 32'd1);
        check("post.addr", imem.imem_addr, 32'h0);
        tick();
        check_id("post.id", mem_word(32'h0), 32'h4, 1'b1, 1'b1);
        check("post.addr2", imem.imem_addr, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
